// File: rtl/rob_pkg.sv
// Package for the reorder buffer slice.
//  - ROB_OP_* : instruction classes tracked by the ROB
//  - TAG_FREE : tag value meaning "no dependency"
//  - CDB_PORT_* : role of each result bus port
//  - ENT_* : bit offsets of the per-entry status/meta vector
//  - rob_state_e : retire/flush FSM states
//  - tag_busy()/tag_idx() : split a tag {busy, idx} of runtime width tag_w
package rob_pkg;

  localparam logic [1:0] ROB_OP_NORMAL = 2'd0;
  localparam logic [1:0] ROB_OP_STORE  = 2'd1;
  localparam logic [1:0] ROB_OP_BRANCH = 2'd2;

  localparam int TAG_FREE = 0;

  localparam int CDB_PORT_ALU    = 0;
  localparam int CDB_PORT_BRANCH = 1;
  localparam int CDB_PORT_LSB    = 2;

  // Per-entry meta vector layout: {op[1:0], mispred, ready, valid}
  localparam int ENT_VALID   = 0;
  localparam int ENT_READY   = 1;
  localparam int ENT_MISPRED = 2;
  localparam int ENT_OP_LSB  = 3;
  localparam int ENT_META_W  = 5;

  // Helpers take tags zero-extended to this width (supports DEPTH up to 128)
  localparam int TAG_MAX_W = 8;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } rob_state_e;

  function automatic logic tag_busy(input logic [TAG_MAX_W-1:0] tag, input int tag_w);
    return tag[tag_w-1];
  endfunction

  function automatic logic [TAG_MAX_W-1:0] tag_idx(input logic [TAG_MAX_W-1:0] tag,
                                                   input int tag_w);
    logic [TAG_MAX_W-1:0] mask;
    mask = (TAG_MAX_W'(1) << (tag_w - 1)) - TAG_MAX_W'(1);
    return tag & mask;
  endfunction

endpackage

// File: rtl/rob_multiport_lookup.sv
// rob_tag_lookup: combinational operand-tag resolver, one instance per check port.
// Configuration macro: ROB_BYPASS_EN (when defined, same-cycle CDB results are
// forwarded; otherwise only the entry array is consulted).
// Ports:
//   chk_tag    in  TAG_W         operand tag; TAG_FREE means no dependency
//   ent_valid  in  DEPTH         per-entry valid bits
//   ent_ready  in  DEPTH         per-entry result-ready bits
//   ent_data   in  DEPTH*DATA_W  per-entry results, entry i at [i*DATA_W +: DATA_W]
//   cdb_valid  in  NCDB          current-cycle result bus valids
//   cdb_tag    in  NCDB*TAG_W    current-cycle result bus tags
//   cdb_data   in  NCDB*DATA_W   current-cycle result bus data
//   chk_rdy    out 1             operand value available
//   chk_data   out DATA_W        operand value, 0 unless chk_rdy with a busy tag
module rob_tag_lookup
  import rob_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int NCDB   = 3,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int TAG_W = IDX_W + 1
) (
  input  logic [TAG_W-1:0]        chk_tag,
  input  logic [DEPTH-1:0]        ent_valid,
  input  logic [DEPTH-1:0]        ent_ready,
  input  logic [DEPTH*DATA_W-1:0] ent_data,
  input  logic [NCDB-1:0]         cdb_valid,
  input  logic [NCDB*TAG_W-1:0]   cdb_tag,
  input  logic [NCDB*DATA_W-1:0]  cdb_data,
  output logic                    chk_rdy,
  output logic [DATA_W-1:0]       chk_data
);

  logic [IDX_W-1:0] idx;

  assign idx = IDX_W'(tag_idx(TAG_MAX_W'(chk_tag), TAG_W));

  always_comb begin
    chk_rdy  = 1'b0;
    chk_data = '0;
    if (chk_tag == TAG_W'(TAG_FREE)) begin
      chk_rdy = 1'b1;
    end else if (ent_valid[idx] && ent_ready[idx]) begin
      chk_rdy  = 1'b1;
      chk_data = ent_data[idx*DATA_W +: DATA_W];
    end
`ifdef ROB_BYPASS_EN
    // Forward a result being broadcast this cycle to a live entry. Ports are
    // scanned high to low so the lowest matching port is the last assignment.
    else if (ent_valid[idx]) begin
      for (int k = NCDB - 1; k >= 0; k--) begin
        if (cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] == chk_tag)) begin
          chk_rdy  = 1'b1;
          chk_data = cdb_data[k*DATA_W +: DATA_W];
        end
      end
    end
`endif
  end

`ifdef ROB_BYPASS_EN
`else
  // Bus inputs are only consumed by the forwarding path.
  logic unused_cdb;
  assign unused_cdb = ^{cdb_valid, cdb_tag, cdb_data};
`endif

endmodule

// File: rtl/rob_multiport.sv
// rob_multiport: circular in-order reorder buffer between decoder and regfile.
// Accepts one instruction per cycle, collects results from NCDB broadcast
// buses, resolves two operand tags, retires one ready head entry per cycle and
// raises a flush when a mispredicted branch retires.
// Configuration macro: ROB_BYPASS_EN (forwarding in rob_tag_lookup).
// Handshake: an instruction is accepted on a rising clk edge where
//   ins_valid && ins_ready; ins_ready never depends on ins_valid and the tag of
//   the accepted instruction is the ins_tag presented in that same cycle.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ins_valid/ins_ready            decoder insert handshake
//   ins_op, ins_reg, ins_tag       op class, destination register, assigned tag
//   cdb_valid/tag/data/mispred     result buses (port 1 = branch, qualified by mispred)
//   chk_tag1/2, chk_rdy1/2, chk_data1/2   operand lookups
//   commit_valid/op/reg/data/tag   registered retire report (one cycle)
//   flush, flush_pc                registered mispredict redirect
//   dbg_state, dbg_count           retire FSM state and occupancy
module rob_multiport
  import rob_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int NCDB   = 3,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int TAG_W = IDX_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  input  logic [1:0]             ins_op,
  input  logic [REG_W-1:0]       ins_reg,
  output logic [TAG_W-1:0]       ins_tag,
  input  logic [NCDB-1:0]        cdb_valid,
  input  logic [NCDB*TAG_W-1:0]  cdb_tag,
  input  logic [NCDB*DATA_W-1:0] cdb_data,
  input  logic                   cdb_mispred,
  input  logic [TAG_W-1:0]       chk_tag1,
  input  logic [TAG_W-1:0]       chk_tag2,
  output logic                   chk_rdy1,
  output logic                   chk_rdy2,
  output logic [DATA_W-1:0]      chk_data1,
  output logic [DATA_W-1:0]      chk_data2,
  output logic                   commit_valid,
  output logic [1:0]             commit_op,
  output logic [REG_W-1:0]       commit_reg,
  output logic [DATA_W-1:0]      commit_data,
  output logic [TAG_W-1:0]       commit_tag,
  output logic                   flush,
  output logic [DATA_W-1:0]      flush_pc,
  output logic [0:0]             dbg_state,
  output logic [IDX_W:0]         dbg_count
);

  // Entry storage
  logic [ENT_META_W-1:0] meta_q [DEPTH];
  logic [REG_W-1:0]      reg_q  [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];

  // Pointers and FSM
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  rob_state_e       state_q, state_d;

  // Registered commit / flush report
  logic              commit_valid_q;
  logic [1:0]        commit_op_q;
  logic [REG_W-1:0]  commit_reg_q;
  logic [DATA_W-1:0] commit_data_q;
  logic [TAG_W-1:0]  commit_tag_q;
  logic [DATA_W-1:0] flush_pc_q;

  logic [ENT_META_W-1:0] head_meta;
  logic                  full;
  logic                  retire;
  logic                  flush_now;
  logic                  ins_fire;

  assign head_meta = meta_q[head_q];
  assign full      = (count_q == (IDX_W+1)'(DEPTH));
  // Retire decisions use registered ready bits only, so a result written on
  // the CDB this cycle can retire at the earliest on the following edge.
  assign retire    = (count_q != '0) && head_meta[ENT_VALID] && head_meta[ENT_READY];
  assign flush_now = retire && head_meta[ENT_MISPRED]
                     && (head_meta[ENT_OP_LSB +: 2] == ROB_OP_BRANCH);
  // No credit from a same-cycle retire; no accept while a flush is in
  // progress or about to happen, so nothing is lost to the flush.
  assign ins_ready = !full && (state_q == ST_RUN) && !flush_now;
  assign ins_fire  = ins_valid && ins_ready;
  assign ins_tag   = {1'b1, tail_q};

  // ---------------------------------------------------------------------------
  // CDB resolution: per entry, pick the lowest-index port carrying its tag.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]  port_idx  [NCDB];
  logic              port_busy [NCDB];
  logic              wr_en     [DEPTH];
  logic [DATA_W-1:0] wr_data   [DEPTH];
  logic              wr_mis    [DEPTH];

  always_comb begin
    for (int k = 0; k < NCDB; k++) begin
      port_idx[k]  = IDX_W'(tag_idx(TAG_MAX_W'(cdb_tag[k*TAG_W +: TAG_W]), TAG_W));
      port_busy[k] = tag_busy(TAG_MAX_W'(cdb_tag[k*TAG_W +: TAG_W]), TAG_W);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wr_en[i]   = 1'b0;
      wr_data[i] = '0;
      wr_mis[i]  = 1'b0;
      for (int k = NCDB - 1; k >= 0; k--) begin
        if (cdb_valid[k] && port_busy[k] && (port_idx[k] == IDX_W'(i))) begin
          wr_en[i]   = 1'b1;
          wr_data[i] = cdb_data[k*DATA_W +: DATA_W];
          wr_mis[i]  = (k == CDB_PORT_BRANCH) && cdb_mispred;
        end
      end
      // Results for free or already-completed entries are dropped.
      wr_en[i] = wr_en[i] && meta_q[i][ENT_VALID] && !meta_q[i][ENT_READY];
    end
  end

  // ---------------------------------------------------------------------------
  // Retire / flush FSM: ST_FLUSH is the single cycle in which flush is shown.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = ST_RUN;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_now) begin
      state_d = ST_FLUSH;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (ins_fire) tail_d = tail_q + IDX_W'(1);
      if (retire)   head_d = head_q + IDX_W'(1);
      case ({ins_fire, retire})
        2'b10:   count_d = count_q + (IDX_W+1)'(1);
        2'b01:   count_d = count_q - (IDX_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_op_q    <= '0;
      commit_reg_q   <= '0;
      commit_data_q  <= '0;
      commit_tag_q   <= '0;
      flush_pc_q     <= '0;
      for (int i = 0; i < DEPTH; i++) meta_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= retire;
      commit_op_q    <= retire ? head_meta[ENT_OP_LSB +: 2] : 2'd0;
      commit_reg_q   <= retire ? reg_q[head_q] : '0;
      commit_data_q  <= retire ? data_q[head_q] : '0;
      commit_tag_q   <= retire ? {1'b1, head_q} : '0;
      flush_pc_q     <= flush_now ? data_q[head_q] : '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_now) begin
          meta_q[i] <= '0;
        end else if (ins_fire && (tail_q == IDX_W'(i))) begin
          meta_q[i][ENT_VALID]         <= 1'b1;
          meta_q[i][ENT_READY]         <= 1'b0;
          meta_q[i][ENT_MISPRED]       <= 1'b0;
          meta_q[i][ENT_OP_LSB +: 2]   <= ins_op;
        end else if (retire && (head_q == IDX_W'(i))) begin
          meta_q[i] <= '0;
        end else if (wr_en[i]) begin
          meta_q[i][ENT_READY]   <= 1'b1;
          meta_q[i][ENT_MISPRED] <= wr_mis[i];
        end
      end
    end
  end

  // Payload storage needs no reset: it is only observed through ready entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (ins_fire && (tail_q == IDX_W'(i))) reg_q[i] <= ins_reg;
      if (wr_en[i] && !flush_now)            data_q[i] <= wr_data[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Operand lookups
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0]        ent_valid;
  logic [DEPTH-1:0]        ent_ready;
  logic [DEPTH*DATA_W-1:0] ent_data;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i]                 = meta_q[i][ENT_VALID];
      ent_ready[i]                 = meta_q[i][ENT_READY];
      ent_data[i*DATA_W +: DATA_W] = data_q[i];
    end
  end

  rob_tag_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NCDB(NCDB)) u_lookup1 (
    .chk_tag   (chk_tag1),
    .ent_valid (ent_valid),
    .ent_ready (ent_ready),
    .ent_data  (ent_data),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .chk_rdy   (chk_rdy1),
    .chk_data  (chk_data1)
  );

  rob_tag_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NCDB(NCDB)) u_lookup2 (
    .chk_tag   (chk_tag2),
    .ent_valid (ent_valid),
    .ent_ready (ent_ready),
    .ent_data  (ent_data),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .chk_rdy   (chk_rdy2),
    .chk_data  (chk_data2)
  );

  assign commit_valid = commit_valid_q;
  assign commit_op    = commit_op_q;
  assign commit_reg   = commit_reg_q;
  assign commit_data  = commit_data_q;
  assign commit_tag   = commit_tag_q;
  assign flush        = (state_q == ST_FLUSH);
  assign flush_pc     = flush_pc_q;
  assign dbg_state    = state_q;
  assign dbg_count    = count_q;

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport: insert/CDB/retire, full, out-of-order
// completion, mispredict flush, lookup forwarding, pointer wrap, reset.
module tb_rob_multiport;
  import rob_pkg::*;

  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int NCDB   = 3;
  localparam int W      = 1 + 2 + REG_W + TAG_W + DATA_W;  // {mis, op, reg, tag, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   ins_valid = 1'b0;
  logic                   ins_ready;
  logic [1:0]             ins_op = '0;
  logic [REG_W-1:0]       ins_reg = '0;
  logic [TAG_W-1:0]       ins_tag;
  logic [NCDB-1:0]        cdb_valid = '0;
  logic [NCDB*TAG_W-1:0]  cdb_tag = '0;
  logic [NCDB*DATA_W-1:0] cdb_data = '0;
  logic                   cdb_mispred = 1'b0;
  logic [TAG_W-1:0]       chk_tag1 = 5'h10;
  logic [TAG_W-1:0]       chk_tag2 = '0;
  logic                   chk_rdy1, chk_rdy2;
  logic [DATA_W-1:0]      chk_data1, chk_data2;
  logic                   commit_valid;
  logic [1:0]             commit_op;
  logic [REG_W-1:0]       commit_reg;
  logic [DATA_W-1:0]      commit_data;
  logic [TAG_W-1:0]       commit_tag;
  logic                   flush;
  logic [DATA_W-1:0]      flush_pc;
  logic [0:0]             dbg_state;
  logic [TAG_W-1:0]       dbg_count;

  rob_multiport dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_op(ins_op), .ins_reg(ins_reg),
    .ins_tag(ins_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_mispred(cdb_mispred),
    .chk_tag1(chk_tag1), .chk_tag2(chk_tag2), .chk_rdy1(chk_rdy1), .chk_rdy2(chk_rdy2),
    .chk_data1(chk_data1), .chk_data2(chk_data2),
    .commit_valid(commit_valid), .commit_op(commit_op), .commit_reg(commit_reg),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .flush(flush), .flush_pc(flush_pc), .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] m_data [16];
  logic [3:0]        m_tail = '0;
  int                n_cmp = 0;
  int                n_bad = 0;
  logic              exp_byp;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cdb();
    cdb_valid   = '0;
    cdb_mispred = 1'b0;
  endtask

  task automatic set_cdb(input int p, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_valid[p]               = 1'b1;
    cdb_tag[p*TAG_W +: TAG_W]  = t;
    cdb_data[p*DATA_W +: DATA_W] = d;
  endtask

  // Presents one instruction for one edge; the entry's eventual result d is
  // decided here so the expected commit record is complete at insert time.
  task automatic do_insert(input logic [1:0] op, input logic [REG_W-1:0] rg,
                           input logic [DATA_W-1:0] d, input logic mis);
    ins_valid = 1'b1;
    ins_op    = op;
    ins_reg   = rg;
    #1;
    chk("ins_tag", ins_tag, {1'b1, m_tail});
    exp_q.push_back({mis, op, rg, 1'b1, m_tail, d});
    m_data[m_tail] = d;
    tick();
    ins_valid = 1'b0;
    m_tail    = m_tail + 4'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    exp_q.delete();
    m_tail = '0;
    rst = 1'b0;
  endtask

  // ---------------- commit monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (commit_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("commit_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("commit_tag", commit_tag, e[DATA_W +: TAG_W]);
        chk("commit_op", commit_op, e[DATA_W+TAG_W+REG_W +: 2]);
        chk("commit_data", commit_data, e[DATA_W-1:0]);
        if (e[DATA_W+TAG_W+REG_W +: 2] == ROB_OP_NORMAL)
          chk("commit_reg", commit_reg, e[DATA_W+TAG_W +: REG_W]);
        if (e[W-1] && (e[DATA_W+TAG_W+REG_W +: 2] == ROB_OP_BRANCH)) begin
          chk("flush_on_mispred", flush, 1);
          chk("flush_pc", flush_pc, e[DATA_W-1:0]);
          exp_q.delete();  // younger entries are squashed
        end else begin
          chk("flush_idle", flush, 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

`ifdef ROB_BYPASS_EN
  assign exp_byp = 1'b1;
`else
  assign exp_byp = 1'b0;
`endif

  // ---------------- directed sequence ----------------
  initial begin
    logic [TAG_W-1:0] prev_tag;
    logic [1:0]       prev_op;
    logic [1:0]       op;

    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_ins_ready", ins_ready, 1);
    chk("rst_ins_tag", ins_tag, 5'h10);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_data", commit_data, 0);
    chk("rst_commit_tag", commit_tag, 0);
    chk("rst_flush", flush, 0);
    chk("rst_flush_pc", flush_pc, 0);
    chk("rst_count", dbg_count, 0);
    chk("rst_chk_rdy1", chk_rdy1, 0);
    chk("rst_chk_data1", chk_data1, 0);
    chk("rst_chk_rdy2_free", chk_rdy2, 1);
    chk("rst_chk_data2_free", chk_data2, 0);

    // Basic insert -> CDB -> commit
    do_insert(ROB_OP_NORMAL, 5'd3, 32'hDEAD, 1'b0);
    set_cdb(CDB_PORT_ALU, 5'h10, 32'hDEAD);
    chk_tag1 = 5'h10;
    #1;
    chk("basic_bypass_rdy", chk_rdy1, exp_byp);
    chk("basic_bypass_data", chk_data1, exp_byp ? 32'hDEAD : 32'h0);
    tick();
    clr_cdb();
    #1;
    chk("basic_rdy_after", chk_rdy1, 1);
    chk("basic_data_after", chk_data1, 32'hDEAD);
    chk("basic_no_same_cycle_retire", commit_valid, 0);
    tick();
    chk("basic_commit_valid", commit_valid, 1);
    chk("basic_commit_reg", commit_reg, 3);
    chk("basic_commit_tag", commit_tag, 5'h10);
    chk("basic_count", dbg_count, 0);
    chk("basic_lookup_retired", chk_rdy1, 0);
    tick();
    chk("basic_commit_one_cycle", commit_valid, 0);

    // Fill to DEPTH, then an extra insert attempt
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("fill_ready", ins_ready, 1);
      do_insert(ROB_OP_NORMAL, REG_W'(i), $urandom, 1'b0);
    end
    chk("full_ins_ready", ins_ready, 0);
    chk("full_count", dbg_count, 16);
    ins_valid = 1'b1;
    tick();
    ins_valid = 1'b0;
    chk("full_extra_count", dbg_count, 16);
    chk("full_extra_tail", ins_tag, 5'h10);

    // Out-of-order completion: 0x11 before 0x10
    set_cdb(CDB_PORT_ALU, 5'h11, m_data[1]);
    tick();
    clr_cdb();
    chk("ooo_no_commit_a", commit_valid, 0);
    tick();
    chk("ooo_no_commit_b", commit_valid, 0);
    set_cdb(CDB_PORT_BRANCH, 5'h10, m_data[0]);
    tick();
    clr_cdb();
    chk("full_no_same_cycle_credit", ins_ready, 0);
    tick();
    chk("ooo_first_tag", commit_tag, 5'h10);
    chk("ooo_ready_after_retire", ins_ready, 1);
    tick();
    chk("ooo_second_tag", commit_tag, 5'h11);
    // Same tag on two ports: port 0 must win over port 2
    set_cdb(CDB_PORT_ALU, 5'h12, m_data[2]);
    set_cdb(CDB_PORT_LSB, 5'h12, ~m_data[2]);
    set_cdb(CDB_PORT_BRANCH, 5'h13, m_data[3]);
    tick();
    clr_cdb();
    for (int j = 4; j < 16; j++) begin
      set_cdb(j % 3, {1'b1, 4'(j)}, m_data[j]);
      tick();
      clr_cdb();
    end
    for (int i = 0; i < 40 && dbg_count != 0; i++) tick();
    tick();
    chk("drain_count", dbg_count, 0);
    chk("drain_queue", exp_q.size(), 0);

    // Mispredicted branch flush
    do_reset();
    do_insert(ROB_OP_NORMAL, 5'd1, 32'h111, 1'b0);
    do_insert(ROB_OP_NORMAL, 5'd2, 32'h222, 1'b0);
    do_insert(ROB_OP_BRANCH, 5'd0, 32'h400, 1'b1);
    do_insert(ROB_OP_NORMAL, 5'd4, 32'h444, 1'b0);
    do_insert(ROB_OP_NORMAL, 5'd5, 32'd5, 1'b0);
    do_insert(ROB_OP_STORE, 5'd6, 32'h666, 1'b0);
    set_cdb(CDB_PORT_ALU, 5'h10, 32'h111);
    set_cdb(CDB_PORT_BRANCH, 5'h12, 32'h400);
    cdb_mispred = 1'b1;
    set_cdb(CDB_PORT_LSB, 5'h11, 32'h222);
    tick();
    clr_cdb();
    set_cdb(CDB_PORT_ALU, 5'h14, 32'd5);
    set_cdb(CDB_PORT_LSB, 5'h13, 32'h444);
    chk_tag1 = 5'h14;
    #1;
    chk("fwd_same_cycle_rdy", chk_rdy1, exp_byp);
    chk("fwd_same_cycle_data", chk_data1, exp_byp ? 32'd5 : 32'd0);
    tick();
    clr_cdb();
    chk("fwd_next_cycle_rdy", chk_rdy1, 1);
    chk("fwd_next_cycle_data", chk_data1, 32'd5);
    for (int i = 0; i < 10 && flush !== 1'b1; i++) tick();
    chk("flush_seen", flush, 1);
    chk("flush_pc_value", flush_pc, 32'h400);
    chk("flush_count", dbg_count, 0);
    chk("flush_tail", ins_tag, 5'h10);
    chk("flush_ins_ready", ins_ready, 0);
    chk_tag1 = 5'h13;
    #1;
    chk("flush_lookup_rdy", chk_rdy1, 0);
    chk("flush_lookup_data", chk_data1, 0);
    tick();
    chk("flush_pulse_end", flush, 0);
    chk("flush_ready_back", ins_ready, 1);
    chk("flush_queue", exp_q.size(), 0);
    m_tail = '0;

    // Full-rate insert/retire stream across two pointer wraps
    prev_tag = '0;
    prev_op  = ROB_OP_NORMAL;
    for (int i = 0; i < 40; i++) begin
      if (i > 0)
        set_cdb((prev_op == ROB_OP_BRANCH) ? CDB_PORT_BRANCH : CDB_PORT_ALU,
                prev_tag, m_data[prev_tag[3:0]]);
      chk("wrap_ready", ins_ready, 1);
      op       = (i % 3 == 0) ? ROB_OP_NORMAL : ((i % 3 == 1) ? ROB_OP_STORE : ROB_OP_BRANCH);
      prev_tag = {1'b1, m_tail};
      prev_op  = op;
      do_insert(op, REG_W'(i), $urandom, 1'b0);
      clr_cdb();
    end
    set_cdb(CDB_PORT_BRANCH, prev_tag, m_data[prev_tag[3:0]]);
    tick();
    clr_cdb();
    for (int i = 0; i < 10 && dbg_count != 0; i++) tick();
    tick();
    chk("wrap_count", dbg_count, 0);
    chk("wrap_queue", exp_q.size(), 0);

    // Reset in the middle of retirement
    do_insert(ROB_OP_NORMAL, 5'd7, 32'hA1, 1'b0);
    do_insert(ROB_OP_NORMAL, 5'd8, 32'hA2, 1'b0);
    do_insert(ROB_OP_NORMAL, 5'd9, 32'hA3, 1'b0);
    set_cdb(0, {1'b1, m_tail - 4'd3}, 32'hA1);
    set_cdb(1, {1'b1, m_tail - 4'd2}, 32'hA2);
    set_cdb(2, {1'b1, m_tail - 4'd1}, 32'hA3);
    tick();
    clr_cdb();
    tick();
    chk("mid_commit_before_rst", commit_valid, 1);
    chk_tag1 = {1'b1, m_tail - 4'd2};
    do_reset();
    chk("mid_rst_commit_valid", commit_valid, 0);
    chk("mid_rst_commit_data", commit_data, 0);
    chk("mid_rst_commit_tag", commit_tag, 0);
    chk("mid_rst_flush", flush, 0);
    chk("mid_rst_count", dbg_count, 0);
    chk("mid_rst_ins_tag", ins_tag, 5'h10);
    chk("mid_rst_ins_ready", ins_ready, 1);
    chk("mid_rst_lookup", chk_rdy1, 0);
    tick();
    chk("mid_rst_no_commit", commit_valid, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
